// File: rtl/efpga_bridge_pkg.sv
// efpga_bridge_pkg: shared types and defaults for the eFPGA operation bridge.
//   - bridge_state_e : issue/complete FSM states
//   - bridge_cmd_t   : one queued command at the default field widths
//   - *_DFLT         : default parameter values, including the handshake TIMEOUT
//   - max_int        : constant helper used to size internal counters
package efpga_bridge_pkg;

  localparam int DATA_W_DFLT    = 32;
  localparam int NUM_RES_DFLT   = 3;
  localparam int OP_W_DFLT      = 2;
  localparam int DELAY_W_DFLT   = 4;
  localparam int TAG_W_DFLT     = 4;
  localparam int CMD_DEPTH_DFLT = 4;
  localparam int TIMEOUT_DFLT   = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bridge_state_e;

  // Default-width command view. The bridge builds the same layout from its
  // own parameters so that non-default widths still pack correctly.
  typedef struct packed {
    logic [DATA_W_DFLT-1:0]  a;
    logic [DATA_W_DFLT-1:0]  b;
    logic [OP_W_DFLT-1:0]    op;
    logic [DELAY_W_DFLT-1:0] delay;
    logic [TAG_W_DFLT-1:0]   tag;
  } bridge_cmd_t;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/efpga_cmd_fifo.sv
// efpga_cmd_fifo: synchronous FIFO, async active-low reset.
//   clk_i/rst_ni       : clock, asynchronous active-low reset
//   push_i/data_i      : write when not full
//   pop_i/data_o       : data_o shows the head; pop_i advances when not empty
//   full_o/empty_o     : status
//   level_o            : stored entries, 0..DEPTH
// DEPTH must be a power of two (>=2). Pointers carry one extra bit so full
// and empty are told apart; the low bits index storage and wrap mod DEPTH.
module efpga_cmd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_LV = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                        do_push, do_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == FULL_LV);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_i;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/efpga_op_bridge.sv
// efpga_op_bridge: queues core operation requests and issues them one at a
// time to the eFPGA fabric, returning tagged multi-word responses.
//   clk_i, reset          : clock, asynchronous active-low reset
//   cmd_*                 : request side; cmd_gnt_o = FIFO not full
//   rsp_*                 : valid/ready response with results, tag, timeout flag
//   eFPGA_*               : fabric operands, one-cycle write strobe, enable,
//                           done handshake and result bus
//   busy_o, fifo_level_o  : FSM not idle, queued command count
// Completion is a fixed latency (delay != 0) or the fabric done handshake
// (delay == 0) guarded by a TIMEOUT-cycle limit.
module efpga_op_bridge
  import efpga_bridge_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DFLT,
  parameter int NUM_RES   = NUM_RES_DFLT,
  parameter int OP_W      = OP_W_DFLT,
  parameter int DELAY_W   = DELAY_W_DFLT,
  parameter int TAG_W     = TAG_W_DFLT,
  parameter int CMD_DEPTH = CMD_DEPTH_DFLT,
  parameter int TIMEOUT   = TIMEOUT_DFLT
) (
  input  logic                         clk_i,
  input  logic                         reset,
  input  logic                         cmd_req_i,
  output logic                         cmd_gnt_o,
  input  logic [DATA_W-1:0]            cmd_operand_a_i,
  input  logic [DATA_W-1:0]            cmd_operand_b_i,
  input  logic [OP_W-1:0]              cmd_operator_i,
  input  logic [DELAY_W-1:0]           cmd_delay_i,
  input  logic [TAG_W-1:0]             cmd_tag_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [NUM_RES*DATA_W-1:0]    rsp_data_o,
  output logic [TAG_W-1:0]             rsp_tag_o,
  output logic                         rsp_err_o,
  output logic [DATA_W-1:0]            eFPGA_operand_a_o,
  output logic [DATA_W-1:0]            eFPGA_operand_b_o,
  output logic [OP_W-1:0]              eFPGA_operator_o,
  output logic [DELAY_W-1:0]           eFPGA_delay_o,
  output logic                         eFPGA_write_strobe_o,
  output logic                         eFPGA_en_o,
  input  logic                         eFPGA_fpga_done_i,
  input  logic [NUM_RES*DATA_W-1:0]    eFPGA_result_i,
  output logic                         busy_o,
  output logic [$clog2(CMD_DEPTH):0]   fifo_level_o
);

  localparam int RES_W = NUM_RES * DATA_W;
  // One counter serves both modes: down-count of the fixed delay or up-count
  // of handshake WAIT cycles, so it is sized for the larger of the two.
  localparam int CNT_W = max_int(DELAY_W, $clog2(TIMEOUT + 1));
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [OP_W-1:0]    op;
    logic [DELAY_W-1:0] delay;
    logic [TAG_W-1:0]   tag;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  bridge_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cmd_t              cur_q, cur_d;
  logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  cmd_t              push_cmd, head_cmd;
  logic              push, pop, fifo_full, fifo_empty;

  assign push_cmd = '{a:     cmd_operand_a_i,
                      b:     cmd_operand_b_i,
                      op:    cmd_operator_i,
                      delay: cmd_delay_i,
                      tag:   cmd_tag_i};

  // Grant is held low while in reset so every output reads 0 there.
  assign cmd_gnt_o = reset & ~fifo_full;
  assign push      = cmd_req_i & cmd_gnt_o;
  assign pop       = (state_q == ST_IDLE) & ~fifo_empty;

  efpga_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (reset),
    .push_i  (push),
    .data_i  (push_cmd),
    .pop_i   (pop),
    .data_o  (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        // Latching the head at pop time puts the fabric fields in place
        // for the ISSUE cycle; they then hold until the next pop.
        if (!fifo_empty) begin
          cur_d   = head_cmd;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // delay==0 loads 0, which is the handshake-mode start count.
        cnt_d   = CNT_W'(cur_q.delay);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cur_q.delay != '0) begin
          if (cnt_q == CNT_ONE) begin
            rsp_data_d = eFPGA_result_i;
            rsp_err_d  = 1'b0;
            state_d    = ST_RESP;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else if (eFPGA_fpga_done_i) begin
          // Checked ahead of the limit so a late done still wins.
          rsp_data_d = eFPGA_result_i;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign busy_o               = (state_q != ST_IDLE);
  assign eFPGA_write_strobe_o = (state_q == ST_ISSUE);
  assign eFPGA_en_o           = (state_q == ST_ISSUE) | (state_q == ST_WAIT);
  assign eFPGA_operand_a_o    = cur_q.a;
  assign eFPGA_operand_b_o    = cur_q.b;
  assign eFPGA_operator_o     = cur_q.op;
  assign eFPGA_delay_o        = cur_q.delay;

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_tag_o   = cur_q.tag;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_efpga_op_bridge.sv
// Directed bench for efpga_op_bridge: fixed-delay, handshake, timeout,
// FIFO full with back-pressure, and reset during WAIT. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_efpga_op_bridge;

  localparam int DATA_W    = 32;
  localparam int NUM_RES   = 3;
  localparam int OP_W      = 2;
  localparam int DELAY_W   = 4;
  localparam int TAG_W     = 4;
  localparam int CMD_DEPTH = 4;
  localparam int TIMEOUT   = 255;
  localparam int RES_W     = NUM_RES * DATA_W;
  localparam int LVL_W     = $clog2(CMD_DEPTH) + 1;

  localparam logic [RES_W-1:0] R1 = 96'h0000_0003_0000_0002_0000_0001;
  localparam logic [RES_W-1:0] R2 = 96'hAAAA_0003_BBBB_0002_CCCC_0001;
  localparam logic [RES_W-1:0] R3 = 96'h1234_5678_9ABC_DEF0_0F0F_0F0F;
  localparam logic [RES_W-1:0] R4 = 96'hDEAD_BEEF_CAFE_F00D_0BAD_F00D;
  localparam logic [RES_W-1:0] R5 = 96'h5555_5555_6666_6666_7777_7777;

  logic               clk_i = 1'b0;
  logic               reset = 1'b0;
  logic               cmd_req_i = 1'b0;
  logic               cmd_gnt_o;
  logic [DATA_W-1:0]  cmd_operand_a_i = '0;
  logic [DATA_W-1:0]  cmd_operand_b_i = '0;
  logic [OP_W-1:0]    cmd_operator_i = '0;
  logic [DELAY_W-1:0] cmd_delay_i = '0;
  logic [TAG_W-1:0]   cmd_tag_i = '0;
  logic               rsp_valid_o;
  logic               rsp_ready_i = 1'b0;
  logic [RES_W-1:0]   rsp_data_o;
  logic [TAG_W-1:0]   rsp_tag_o;
  logic               rsp_err_o;
  logic [DATA_W-1:0]  eFPGA_operand_a_o;
  logic [DATA_W-1:0]  eFPGA_operand_b_o;
  logic [OP_W-1:0]    eFPGA_operator_o;
  logic [DELAY_W-1:0] eFPGA_delay_o;
  logic               eFPGA_write_strobe_o;
  logic               eFPGA_en_o;
  logic               eFPGA_fpga_done_i = 1'b0;
  logic [RES_W-1:0]   eFPGA_result_i = '0;
  logic               busy_o;
  logic [LVL_W-1:0]   fifo_level_o;

  int total = 0;
  int bad   = 0;

  efpga_op_bridge #(
    .DATA_W (DATA_W), .NUM_RES (NUM_RES), .OP_W (OP_W), .DELAY_W (DELAY_W),
    .TAG_W (TAG_W), .CMD_DEPTH (CMD_DEPTH), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i                (clk_i),
    .reset                (reset),
    .cmd_req_i            (cmd_req_i),
    .cmd_gnt_o            (cmd_gnt_o),
    .cmd_operand_a_i      (cmd_operand_a_i),
    .cmd_operand_b_i      (cmd_operand_b_i),
    .cmd_operator_i       (cmd_operator_i),
    .cmd_delay_i          (cmd_delay_i),
    .cmd_tag_i            (cmd_tag_i),
    .rsp_valid_o          (rsp_valid_o),
    .rsp_ready_i          (rsp_ready_i),
    .rsp_data_o           (rsp_data_o),
    .rsp_tag_o            (rsp_tag_o),
    .rsp_err_o            (rsp_err_o),
    .eFPGA_operand_a_o    (eFPGA_operand_a_o),
    .eFPGA_operand_b_o    (eFPGA_operand_b_o),
    .eFPGA_operator_o     (eFPGA_operator_o),
    .eFPGA_delay_o        (eFPGA_delay_o),
    .eFPGA_write_strobe_o (eFPGA_write_strobe_o),
    .eFPGA_en_o           (eFPGA_en_o),
    .eFPGA_fpga_done_i    (eFPGA_fpga_done_i),
    .eFPGA_result_i       (eFPGA_result_i),
    .busy_o               (busy_o),
    .fifo_level_o         (fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!rsp_valid_o && n < max) begin tick(); n++; end
  endtask

  task automatic wait_strobe(input int max, output int n);
    n = 0;
    while (!eFPGA_write_strobe_o && n < max) begin tick(); n++; end
  endtask

  task automatic set_cmd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [OP_W-1:0] op, input logic [DELAY_W-1:0] dly,
                         input logic [TAG_W-1:0] tag);
    cmd_operand_a_i = a;
    cmd_operand_b_i = b;
    cmd_operator_i  = op;
    cmd_delay_i     = dly;
    cmd_tag_i       = tag;
  endtask

  // Presents one command, holds it until granted, returns on the falling
  // edge right after the accepting rising edge.
  task automatic push1(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [OP_W-1:0] op, input logic [DELAY_W-1:0] dly,
                       input logic [TAG_W-1:0] tag);
    int n;
    n = 0;
    set_cmd(a, b, op, dly, tag);
    cmd_req_i = 1'b1;
    while (!cmd_gnt_o && n < 50) begin tick(); n++; end
    chk("push_granted", n < 50, 1);
    tick();
    cmd_req_i = 1'b0;
  endtask

  initial begin
    int n, early, unstable, strobes, gnt_seen, held;

    // ---- reset state
    tick(); tick();
    chk("rst_gnt", cmd_gnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_level", fifo_level_o, 0);
    chk("rst_en", eFPGA_en_o, 0);
    reset = 1'b1;
    #1;
    chk("rel_gnt", cmd_gnt_o, 1);

    // ---- fixed delay 3
    rsp_ready_i    = 1'b1;
    eFPGA_result_i = R1;
    push1(32'd5, 32'd7, 2'd1, 4'd3, 4'd2);
    chk("t1_level", fifo_level_o, 1);
    wait_strobe(10, n);
    chk("t1_pop_lat", n, 1);
    chk("t1_en_issue", eFPGA_en_o, 1);
    chk("t1_fields", {eFPGA_operand_a_o, eFPGA_operand_b_o, eFPGA_operator_o, eFPGA_delay_o},
        {32'd5, 32'd7, 2'd1, 4'd3});
    chk("t1_level_after_pop", fifo_level_o, 0);
    tick();
    chk("t1_strobe_1cyc", eFPGA_write_strobe_o, 0);
    chk("t1_en_wait", eFPGA_en_o, 1);
    wait_valid(20, n);
    chk("t1_rsp_lat", n + 1, 4);
    chk("t1_data", rsp_data_o, R1);
    chk("t1_tag", rsp_tag_o, 2);
    chk("t1_err", rsp_err_o, 0);
    chk("t1_en_resp", eFPGA_en_o, 0);
    tick();
    chk("t1_done_idle", {rsp_valid_o, busy_o}, 2'b00);
    chk("t1_hold_a", eFPGA_operand_a_o, 5);

    // ---- handshake, done pulsed during ISSUE must be ignored
    eFPGA_result_i = R2;
    push1(32'h11, 32'h22, 2'd2, 4'd0, 4'd5);
    tick();
    chk("t2_strobe", eFPGA_write_strobe_o, 1);
    eFPGA_fpga_done_i = 1'b1;
    tick();
    eFPGA_fpga_done_i = 1'b0;
    early = 0;
    for (int i = 1; i < 10; i++) begin
      if (rsp_valid_o) early++;
      tick();
    end
    chk("t2_issue_done_ignored", early, 0);
    chk("t2_en_wait", eFPGA_en_o, 1);
    eFPGA_fpga_done_i = 1'b1;
    tick();
    eFPGA_fpga_done_i = 1'b0;
    chk("t2_valid", rsp_valid_o, 1);
    chk("t2_data", rsp_data_o, R2);
    chk("t2_tag_err", {rsp_tag_o, rsp_err_o}, {4'd5, 1'b0});
    tick();

    // ---- timeout, then the queued command issues
    eFPGA_result_i = R3;
    push1(32'h1, 32'h2, 2'd0, 4'd0, 4'd7);
    push1(32'h3, 32'h4, 2'd3, 4'd2, 4'd8);
    chk("t3_strobe", eFPGA_write_strobe_o, 1);
    chk("t3_a", eFPGA_operand_a_o, 32'h1);
    wait_valid(400, n);
    chk("t3_timeout_lat", n, 1 + TIMEOUT);
    chk("t3_err", rsp_err_o, 1);
    chk("t3_data_zero", rsp_data_o, 0);
    chk("t3_tag", rsp_tag_o, 7);
    chk("t3_level", fifo_level_o, 1);
    tick();
    chk("t3_idle", busy_o, 0);
    tick();
    chk("t3_next_strobe", eFPGA_write_strobe_o, 1);
    chk("t3_next_fields", {eFPGA_operand_a_o, eFPGA_delay_o}, {32'h3, 4'd2});
    wait_valid(20, n);
    chk("t3_next_lat", n, 3);
    chk("t3_next_tag_err", {rsp_tag_o, rsp_err_o}, {4'd8, 1'b0});
    chk("t3_next_data", rsp_data_o, R3);
    tick();

    // ---- back-pressure and FIFO full
    rsp_ready_i    = 1'b0;
    eFPGA_result_i = R4;
    push1(32'h100, 32'h0, 2'd1, 4'd1, 4'd1);
    wait_valid(10, n);
    chk("t4_first_lat", n, 3);
    chk("t4_first_tag", rsp_tag_o, 1);
    eFPGA_result_i = R5;
    for (int t = 2; t <= 5; t++) push1(32'(t), 32'h0, 2'd1, 4'd1, 4'(t));
    set_cmd(32'd6, 32'h0, 2'd1, 4'd1, 4'd6);
    cmd_req_i = 1'b1;
    chk("t4_full_gnt", cmd_gnt_o, 0);
    chk("t4_level_peak", fifo_level_o, CMD_DEPTH);
    unstable = 0; strobes = 0; gnt_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_gnt_o) gnt_seen++;
      if (!rsp_valid_o || rsp_data_o !== R4 || rsp_tag_o !== 4'd1 || rsp_err_o) unstable++;
      if (eFPGA_write_strobe_o) strobes++;
      tick();
    end
    chk("t5_rsp_stable", unstable, 0);
    chk("t5_no_strobe", strobes, 0);
    chk("t5_held_full", gnt_seen, 0);
    rsp_ready_i = 1'b1;
    held = 0;
    while (!cmd_gnt_o && held < 20) begin tick(); held++; end
    chk("t4_slot_free_lat", held, 2);
    tick();
    cmd_req_i = 1'b0;
    for (int t = 2; t <= 6; t++) begin
      wait_valid(20, n);
      chk("t4_order_tag", rsp_tag_o, t);
      tick();
    end

    // ---- reset during WAIT
    push1(32'h9, 32'h0, 2'd0, 4'd0, 4'd9);
    push1(32'hA, 32'h0, 2'd0, 4'd1, 4'd10);
    tick(); tick();
    chk("t6_in_wait", {busy_o, eFPGA_en_o, fifo_level_o}, {1'b1, 1'b1, 3'd1});
    reset = 1'b0;
    #1;
    chk("t6_rst_ctrl", {busy_o, eFPGA_en_o, eFPGA_write_strobe_o, rsp_valid_o, cmd_gnt_o}, 0);
    chk("t6_rst_level", fifo_level_o, 0);
    chk("t6_rst_data", {eFPGA_operand_a_o, rsp_tag_o, rsp_data_o}, 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("t6_rel_gnt", cmd_gnt_o, 1);
    early = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid_o || eFPGA_write_strobe_o) early++;
      tick();
    end
    chk("t6_no_ghost", early, 0);
    chk("t6_level_after", fifo_level_o, 0);
    push1(32'h33, 32'h44, 2'd2, 4'd2, 4'd3);
    wait_strobe(10, n);
    chk("t6_new_pop_lat", n, 1);
    chk("t6_new_a", eFPGA_operand_a_o, 32'h33);
    wait_valid(20, n);
    chk("t6_new_lat", n, 3);
    chk("t6_new_rsp", {rsp_tag_o, rsp_err_o, rsp_data_o}, {4'd3, 1'b0, R5});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
